// File: rtl/us_cmd_master_if.sv
// us_cmd_master_if: FSL command/reply channels plus the tagged sample output stream.
// The master modport is the command initiator's view; slave is the receiver/sink side.
interface us_cmd_master_if;
  logic        FSL_M_Write;
  logic [31:0] FSL_M_Data;
  logic        FSL_M_Control;
  logic        FSL_M_Full;
  logic        FSL_S_Read;
  logic [31:0] FSL_S_Data;
  logic        FSL_S_Control;
  logic        FSL_S_Exists;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_SENSOR;
  logic        OUT_READY;

  modport master (
    output FSL_M_Write, FSL_M_Data, FSL_M_Control,
    input  FSL_M_Full,
    output FSL_S_Read,
    input  FSL_S_Data, FSL_S_Control, FSL_S_Exists,
    output OUT_VALID, OUT_DATA, OUT_SENSOR,
    input  OUT_READY
  );

  modport slave (
    input  FSL_M_Write, FSL_M_Data, FSL_M_Control,
    output FSL_M_Full,
    input  FSL_S_Read,
    output FSL_S_Data, FSL_S_Control, FSL_S_Exists,
    input  OUT_VALID, OUT_DATA, OUT_SENSOR,
    output OUT_READY
  );
endinterface

// File: rtl/us_cmd_master.sv
// us_cmd_master: autonomous scan sequencer for the us_receiver command interface.
// Echo link check, Init, then one Sample command per enabled sensor with replies streamed out.
module us_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [27:0] ECHO_PATTERN   = 28'hAAAAAAA
) (
  input  logic            FSL_Clk,
  input  logic            FSL_Rst,
  input  logic            START,
  input  logic [15:0]     SENSOR_MASK,
  input  logic [23:0]     SAMPLE_COUNT,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERROR,
  output logic [1:0]      ERR_CODE,
  us_cmd_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    ECHO_TX,
    ECHO_RX,
    INIT_TX,
    SEL,
    SMP_TX,
    SMP_RX,
    FIN_WAIT,
    PULSE
  } state_t;

  localparam logic [3:0]  OP_ECHO   = 4'h0;
  localparam logic [3:0]  OP_INIT   = 4'h3;
  localparam logic [3:0]  OP_SAMPLE = 4'h2;
  localparam logic [31:0] ECHO_WORD = {ECHO_PATTERN, OP_ECHO};
  localparam logic [12:0] TO_LAST   = 13'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_ECHO    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CTRL    = 2'd3;

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [23:0] count_q, count_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] remaining_q, remaining_d;
  logic [12:0] to_cnt_q, to_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_sensor_q, out_sensor_d;

  logic        tx_state;
  logic        m_write;
  logic [31:0] m_data;
  logic        s_read;
  logic        hold;
  logic        finish_req;
  logic [1:0]  fail_code;

  // Handshake strobes are combinational so a write never lands on a cycle where Full is high.
  always_comb begin
    tx_state = (state_q == ECHO_TX) || (state_q == INIT_TX) || (state_q == SMP_TX);
    m_write  = tx_state & ~bus.FSL_M_Full;
    m_data   = 32'h0;
    s_read   = 1'b0;
    case (state_q)
      ECHO_TX: m_data = ECHO_WORD;
      INIT_TX: m_data = {28'h0, OP_INIT};
      SMP_TX:  m_data = {count_q, idx_q, OP_SAMPLE};
      ECHO_RX: s_read = bus.FSL_S_Exists;
      SMP_RX:  s_read = bus.FSL_S_Exists & (~out_valid_q | bus.OUT_READY);
      default: ;
    endcase
    hold = out_valid_q & ~bus.OUT_READY;
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    count_d      = count_q;
    idx_d        = idx_q;
    remaining_d  = remaining_q;
    to_cnt_d     = 13'd0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    out_valid_d  = out_valid_q & ~bus.OUT_READY;
    out_data_d   = out_data_q;
    out_sensor_d = out_sensor_q;
    finish_req   = 1'b0;
    fail_code    = 2'd0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = ECHO_TX;
          mask_d     = SENSOR_MASK;
          count_d    = SAMPLE_COUNT;
          err_code_d = 2'd0;
          busy_d     = 1'b1;
        end
      end
      ECHO_TX: begin
        if (m_write) state_d = ECHO_RX;
      end
      ECHO_RX: begin
        if (s_read) begin
          if (bus.FSL_S_Control)              fail_code = ERR_CTRL;
          else if (bus.FSL_S_Data != ECHO_WORD) fail_code = ERR_ECHO;
          else                                state_d   = INIT_TX;
        end else if (to_cnt_q == TO_LAST) begin
          fail_code = ERR_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + 13'd1;
        end
      end
      INIT_TX: begin
        if (m_write) begin
          state_d = SEL;
          idx_d   = 4'd0;
        end
      end
      // Finishing as soon as no mask bits remain at or above idx avoids walking empty tails.
      SEL: begin
        if ((count_q == 24'd0) || ((mask_q >> idx_q) == 16'h0)) finish_req = 1'b1;
        else if (mask_q[idx_q])                                 state_d    = SMP_TX;
        else                                                    idx_d      = idx_q + 4'd1;
      end
      SMP_TX: begin
        if (m_write) begin
          state_d     = SMP_RX;
          remaining_d = count_q;
        end
      end
      SMP_RX: begin
        if (s_read) begin
          if (bus.FSL_S_Control) begin
            fail_code = ERR_CTRL;
          end else begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.FSL_S_Data;
            out_sensor_d = idx_q;
            remaining_d  = remaining_q - 24'd1;
            if (remaining_q == 24'd1) begin
              if (idx_q == 4'd15) begin
                finish_req = 1'b1;
              end else begin
                idx_d   = idx_q + 4'd1;
                state_d = SEL;
              end
            end
          end
        end else if (hold) begin
          to_cnt_d = to_cnt_q;
        end else if (to_cnt_q == TO_LAST) begin
          fail_code = ERR_TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + 13'd1;
        end
      end
      FIN_WAIT: finish_req = 1'b1;
      PULSE:    state_d    = IDLE;
      default:  state_d    = IDLE;
    endcase

    if (fail_code != 2'd0) begin
      err_code_d = fail_code;
      finish_req = 1'b1;
    end

    // The completion pulse is held back until the last sample has left the output register.
    if (finish_req) begin
      if (out_valid_d) begin
        state_d = FIN_WAIT;
      end else begin
        state_d = PULSE;
        busy_d  = 1'b0;
        done_d  = (err_code_d == 2'd0);
        error_d = (err_code_d != 2'd0);
      end
    end
  end

  always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
    if (FSL_Rst) begin
      state_q      <= IDLE;
      mask_q       <= 16'h0;
      count_q      <= 24'h0;
      idx_q        <= 4'h0;
      remaining_q  <= 24'h0;
      to_cnt_q     <= 13'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      out_sensor_q <= 4'h0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      remaining_q  <= remaining_d;
      to_cnt_q     <= to_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sensor_q <= out_sensor_d;
    end
  end

  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign ERROR             = error_q;
  assign ERR_CODE          = err_code_q;
  assign bus.FSL_M_Write   = m_write;
  assign bus.FSL_M_Data    = m_data;
  assign bus.FSL_M_Control = 1'b0;
  assign bus.FSL_S_Read    = s_read;
  assign bus.OUT_VALID     = out_valid_q;
  assign bus.OUT_DATA      = out_data_q;
  assign bus.OUT_SENSOR    = out_sensor_q;

endmodule

// File: tb/tb_us_cmd_master.sv
// tb_us_cmd_master: table of scan scenarios against a reply-generating receiver model,
// plus hand sequences for reset mid-scan, echo mismatch, control word and timeout.
module tb_us_cmd_master;

  logic        clk;
  logic        rst;
  logic        START;
  logic [15:0] SENSOR_MASK;
  logic [23:0] SAMPLE_COUNT;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [1:0]  ERR_CODE;

  us_cmd_master_if bus();

  us_cmd_master #(.TIMEOUT_CYCLES(16), .ECHO_PATTERN(28'hAAAAAAA)) dut (
    .FSL_Clk      (clk),
    .FSL_Rst      (rst),
    .START        (START),
    .SENSOR_MASK  (SENSOR_MASK),
    .SAMPLE_COUNT (SAMPLE_COUNT),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERROR        (ERROR),
    .ERR_CODE     (ERR_CODE),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    logic [23:0] count;
    bit          ready_toggle;
    bit          full_stall;
    int          exp_cmds;
    int          exp_samples;
  } scan_vec_t;

  localparam logic [31:0] ECHO_CMD = 32'hAAAAAAA0;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [32:0] reply_q[$];
  logic [31:0] cmd_log[$];
  logic [35:0] out_log[$];
  logic [31:0] exp_cmd[$];
  logic [35:0] exp_out[$];

  int          cyc = 0;
  bit          pop_pending = 0;
  int          done_cnt, err_cnt, done_cyc, err_cyc;
  int          last_accept_edge, last_consume_edge, protocol_viol;
  logic        busy_at_pulse;
  logic [1:0]  code_at_pulse;

  bit          ready_toggle = 0;
  bit          ready_low = 0;
  bit          full_stall = 0;
  int          full_hold = 0;
  bit          echo_override_en = 0;
  logic [31:0] echo_override = 32'h0;
  int          sample_limit = -1;
  bit          ctrl_first = 0;

  function automatic logic [31:0] sample_word(input logic [3:0] s, input int k);
    return {4'hC, s, 8'h5A, 16'(k)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic respond(input logic [31:0] cmd);
    int n;
    if (cmd[3:0] == 4'h0) begin
      reply_q.push_back({1'b0, echo_override_en ? echo_override : cmd});
    end else if (cmd[3:0] == 4'h2) begin
      n = int'(cmd[31:8]);
      if (sample_limit >= 0 && sample_limit < n) n = sample_limit;
      for (int k = 0; k < n; k++)
        reply_q.push_back({1'(ctrl_first && k == 0), sample_word(cmd[7:4], k)});
    end
  endtask

  // Receiver/sink model: drives inputs 1ns after each rising edge, samples handshakes on the falling edge.
  initial begin : agent
    bus.FSL_M_Full    = 1'b0;
    bus.FSL_S_Data    = 32'h0;
    bus.FSL_S_Control = 1'b0;
    bus.FSL_S_Exists  = 1'b0;
    bus.OUT_READY     = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        reply_q.delete();
        pop_pending = 0;
      end else if (pop_pending) begin
        if (reply_q.size() > 0) reply_q.delete(0);
        pop_pending = 0;
      end
      if (reply_q.size() > 0) begin
        {bus.FSL_S_Control, bus.FSL_S_Data} = reply_q[0];
        bus.FSL_S_Exists = 1'b1;
      end else begin
        bus.FSL_S_Control = 1'b0;
        bus.FSL_S_Data    = 32'h0;
        bus.FSL_S_Exists  = 1'b0;
      end
      if (ready_low)         bus.OUT_READY = 1'b0;
      else if (ready_toggle) bus.OUT_READY = ~bus.OUT_READY;
      else                   bus.OUT_READY = 1'b1;
      if (full_stall && full_hold > 0) begin
        bus.FSL_M_Full = 1'b1;
        full_hold--;
      end else begin
        bus.FSL_M_Full = 1'b0;
      end
      @(negedge clk);
      if (bus.FSL_S_Read && bus.FSL_S_Exists) begin
        pop_pending       = 1;
        last_consume_edge = cyc + 1;
      end
      if (bus.FSL_M_Write) begin
        if (bus.FSL_M_Full || bus.FSL_M_Control) protocol_viol++;
        cmd_log.push_back(bus.FSL_M_Data);
        respond(bus.FSL_M_Data);
        full_hold = 5;
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        out_log.push_back({bus.OUT_SENSOR, bus.OUT_DATA});
        last_accept_edge = cyc + 1;
      end
      if (DONE) begin
        done_cnt++;
        done_cyc      = cyc;
        busy_at_pulse = BUSY;
        code_at_pulse = ERR_CODE;
      end
      if (ERROR) begin
        err_cnt++;
        err_cyc       = cyc;
        busy_at_pulse = BUSY;
        code_at_pulse = ERR_CODE;
      end
    end
  end

  task automatic resetLogs();
    cmd_log.delete();
    out_log.delete();
    reply_q.delete();
    pop_pending   = 0;
    done_cnt      = 0;
    err_cnt       = 0;
    done_cyc      = -1;
    err_cyc       = -1;
    protocol_viol = 0;
    last_accept_edge  = -1;
    last_consume_edge = -1;
  endtask

  task automatic buildModel(input logic [15:0] mask, input logic [23:0] count);
    exp_cmd.delete();
    exp_out.delete();
    exp_cmd.push_back(ECHO_CMD);
    exp_cmd.push_back(32'h00000003);
    if (count != 24'd0) begin
      for (int s = 0; s < 16; s++) begin
        if (mask[s]) begin
          exp_cmd.push_back({count, 4'(s), 4'h2});
          for (int k = 0; k < int'(count); k++) exp_out.push_back({4'(s), sample_word(4'(s), k)});
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input logic [23:0] count);
    @(posedge clk);
    #1;
    SENSOR_MASK  = mask;
    SAMPLE_COUNT = count;
    START        = 1'b1;
    @(posedge clk);
    #1;
    START = 1'b0;
  endtask

  task automatic waitEnd(input int budget);
    bit finished;
    finished = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt + err_cnt > 0) begin
        finished = 1;
        break;
      end
    end
    checkOutput("scan_finished", 64'(finished), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic runScan(input scan_vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    resetLogs();
    ready_toggle = v.ready_toggle;
    full_stall   = v.full_stall;
    full_hold    = 5;
    buildModel(v.mask, v.count);
    applyStimulus(v.mask, v.count);
    checkOutput({tag, "_busy_after_start"}, 64'(BUSY), 64'd1);
    checkOutput({tag, "_errcode_cleared"}, 64'(ERR_CODE), 64'd0);
    waitEnd(3000);
    checkOutput({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, "_error_pulses"}, 64'(err_cnt), 64'd0);
    checkOutput({tag, "_busy_at_done"}, 64'(busy_at_pulse), 64'd0);
    checkOutput({tag, "_cmd_count"}, 64'(cmd_log.size()), 64'(v.exp_cmds));
    for (int i = 0; i < exp_cmd.size(); i++)
      if (i < cmd_log.size()) checkOutput($sformatf("%s_cmd%0d", tag, i), 64'(cmd_log[i]), 64'(exp_cmd[i]));
    checkOutput({tag, "_sample_count"}, 64'(out_log.size()), 64'(v.exp_samples));
    for (int i = 0; i < exp_out.size(); i++)
      if (i < out_log.size()) checkOutput($sformatf("%s_out%0d", tag, i), 64'(out_log[i]), 64'(exp_out[i]));
    if (v.exp_samples > 0)
      checkOutput({tag, "_done_after_last_accept"}, 64'(done_cyc), 64'(last_accept_edge));
    checkOutput({tag, "_protocol_viol"}, 64'(protocol_viol), 64'd0);
    ready_toggle = 0;
    full_stall   = 0;
  endtask

  scan_vec_t vecs[7];

  initial begin : main
    bit stalled;
    vecs[0] = '{mask: 16'h0001, count: 24'd1, ready_toggle: 0, full_stall: 0, exp_cmds: 3, exp_samples: 1};
    vecs[1] = '{mask: 16'h0020, count: 24'd2, ready_toggle: 0, full_stall: 0, exp_cmds: 3, exp_samples: 2};
    vecs[2] = '{mask: 16'h8001, count: 24'd3, ready_toggle: 1, full_stall: 1, exp_cmds: 4, exp_samples: 6};
    vecs[3] = '{mask: 16'hFFFF, count: 24'd0, ready_toggle: 0, full_stall: 0, exp_cmds: 2, exp_samples: 0};
    vecs[4] = '{mask: 16'h0000, count: 24'd5, ready_toggle: 0, full_stall: 0, exp_cmds: 2, exp_samples: 0};
    vecs[5] = '{mask: 16'h0101, count: 24'd1, ready_toggle: 0, full_stall: 1, exp_cmds: 4, exp_samples: 2};
    vecs[6] = '{mask: 16'h0006, count: 24'd4, ready_toggle: 1, full_stall: 0, exp_cmds: 4, exp_samples: 8};

    rst          = 1'b1;
    START        = 1'b0;
    SENSOR_MASK  = 16'h0;
    SAMPLE_COUNT = 24'h0;
    resetLogs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(BUSY), 64'd0);
    checkOutput("reset_done", 64'(DONE), 64'd0);
    checkOutput("reset_error", 64'(ERROR), 64'd0);
    checkOutput("reset_errcode", 64'(ERR_CODE), 64'd0);
    checkOutput("reset_out_valid", 64'(bus.OUT_VALID), 64'd0);
    checkOutput("reset_m_write", 64'(bus.FSL_M_Write), 64'd0);
    rst = 1'b0;

    $display("[TB] reset during sample collection");
    resetLogs();
    ready_low = 1;
    applyStimulus(16'h0003, 24'd4);
    stalled = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.OUT_VALID) begin
        stalled = 1;
        break;
      end
    end
    checkOutput("stall_reached", 64'(stalled), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post_reset_out_valid", 64'(bus.OUT_VALID), 64'd0);
    checkOutput("post_reset_busy", 64'(BUSY), 64'd0);
    ready_low = 0;
    resetLogs();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("post_reset_no_pulse", 64'(done_cnt + err_cnt), 64'd0);
    checkOutput("post_reset_no_stale_out", 64'(out_log.size()), 64'd0);
    checkOutput("post_reset_no_cmd", 64'(cmd_log.size()), 64'd0);

    $display("[TB] table-driven scans");
    for (int i = 0; i < 7; i++) runScan(vecs[i], i);

    $display("[TB] echo mismatch");
    resetLogs();
    echo_override_en = 1;
    echo_override    = 32'hAAAAAAA1;
    applyStimulus(16'h0001, 24'd1);
    waitEnd(500);
    checkOutput("echo_err_pulses", 64'(err_cnt), 64'd1);
    checkOutput("echo_done_pulses", 64'(done_cnt), 64'd0);
    checkOutput("echo_err_code", 64'(code_at_pulse), 64'd1);
    checkOutput("echo_busy_at_error", 64'(busy_at_pulse), 64'd0);
    checkOutput("echo_no_init", 64'(cmd_log.size()), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("echo_err_code_held", 64'(ERR_CODE), 64'd1);
    echo_override_en = 0;

    $display("[TB] control word in sample reply");
    resetLogs();
    ctrl_first = 1;
    applyStimulus(16'h0001, 24'd2);
    checkOutput("ctrl_errcode_cleared", 64'(ERR_CODE), 64'd0);
    waitEnd(500);
    checkOutput("ctrl_err_pulses", 64'(err_cnt), 64'd1);
    checkOutput("ctrl_err_code", 64'(code_at_pulse), 64'd3);
    checkOutput("ctrl_not_forwarded", 64'(out_log.size()), 64'd0);
    ctrl_first = 0;

    $display("[TB] reply timeout and START while busy");
    resetLogs();
    sample_limit = 1;
    applyStimulus(16'h0004, 24'd2);
    applyStimulus(16'hFFFF, 24'd7);
    waitEnd(500);
    checkOutput("to_err_pulses", 64'(err_cnt), 64'd1);
    checkOutput("to_err_code", 64'(code_at_pulse), 64'd2);
    checkOutput("to_latency", 64'(err_cyc - last_consume_edge), 64'd16);
    checkOutput("to_cmd_count", 64'(cmd_log.size()), 64'd3);
    if (cmd_log.size() >= 3) checkOutput("to_sample_cmd", 64'(cmd_log[2]), 64'h00000222);
    checkOutput("to_sample_out_count", 64'(out_log.size()), 64'd1);
    if (out_log.size() >= 1) checkOutput("to_sample_out", 64'(out_log[0]), 64'({4'd2, sample_word(4'd2, 0)}));
    sample_limit = -1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
